// File: rtl/timer_pkg.sv
// Shared definitions for the memory-mapped down-counter timer: register map,
// CTRL field layout, mode encodings and FSM states.
package timer_pkg;

  localparam int unsigned DATA_W = 32;
  localparam int unsigned ADDR_W = 2;
  localparam int unsigned CTRL_W = 4;

  localparam logic [ADDR_W-1:0] ADDR_CTRL   = 2'd0;
  localparam logic [ADDR_W-1:0] ADDR_PRESET = 2'd1;
  localparam logic [ADDR_W-1:0] ADDR_COUNT  = 2'd2;
  localparam logic [ADDR_W-1:0] ADDR_RSVD   = 2'd3;

  localparam int unsigned CTRL_EN_BIT      = 0;
  localparam int unsigned CTRL_MODE_LO_BIT = 1;
  localparam int unsigned CTRL_MODE_HI_BIT = 2;
  localparam int unsigned CTRL_IM_BIT      = 3;

  localparam logic [1:0] MODE_ONESHOT = 2'b00;
  localparam logic [1:0] MODE_RELOAD  = 2'b01;

  // Field order mirrors the CTRL bit positions (IM is bit 3, Enable is bit 0).
  typedef struct packed {
    logic       im;
    logic [1:0] mode;
    logic       en;
  } ctrl_t;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    LOAD = 2'd1,
    CNT  = 2'd2,
    INT  = 2'd3
  } state_e;

endpackage

// File: rtl/timer_counter.sv
// Programmable 32-bit down-counter peripheral with one-shot / auto-reload modes
// and a masked interrupt, register-mapped on a word-addressed device port.
module timer_counter
  import timer_pkg::*;
(
  input  logic              clk,
  input  logic              rst,
  input  logic [ADDR_W-1:0] addr,
  input  logic              we,
  input  logic [DATA_W-1:0] din,
  output logic [DATA_W-1:0] dout,
  output logic              irq
);

  state_e            r_state;
  ctrl_t             r_ctrl;
  logic [DATA_W-1:0] r_preset;
  logic [DATA_W-1:0] r_count;
  logic              r_flag;

  state_e            w_state_nxt;
  ctrl_t             w_ctrl_nxt;
  logic [DATA_W-1:0] w_preset_nxt;
  logic [DATA_W-1:0] w_count_nxt;
  logic              w_flag_nxt;
  logic              w_reload;
  logic              w_wr_ctrl;
  logic              w_wr_preset;

  assign w_reload    = (r_ctrl.mode == MODE_RELOAD);
  assign w_wr_ctrl   = we && (addr == ADDR_CTRL);
  assign w_wr_preset = we && (addr == ADDR_PRESET);

  // State and register file; reset is synchronous.
  always_ff @(posedge clk) begin
    if (!rst) begin
      r_state  <= IDLE;
      r_ctrl   <= '0;
      r_preset <= '0;
      r_count  <= '0;
      r_flag   <= 1'b0;
    end else begin
      r_state  <= w_state_nxt;
      r_ctrl   <= w_ctrl_nxt;
      r_preset <= w_preset_nxt;
      r_count  <= w_count_nxt;
      r_flag   <= w_flag_nxt;
    end
  end

  // Next-state logic; bus writes are applied last so they override the FSM.
  always_comb begin
    w_state_nxt  = r_state;
    w_ctrl_nxt   = r_ctrl;
    w_preset_nxt = r_preset;
    w_count_nxt  = r_count;
    w_flag_nxt   = r_flag;

    case (r_state)
      IDLE: begin
        if (r_ctrl.en) w_state_nxt = LOAD;
      end
      LOAD: begin
        w_count_nxt = r_preset;
        w_state_nxt = CNT;
      end
      CNT: begin
        if (!r_ctrl.en) begin
          w_state_nxt = IDLE;
        end else if (r_count > DATA_W'(1)) begin
          w_count_nxt = r_count - DATA_W'(1);
        end else begin
          w_count_nxt = '0;
          w_flag_nxt  = 1'b1;
          w_state_nxt = INT;
        end
      end
      INT: begin
        w_state_nxt = IDLE;
        if (w_reload) w_flag_nxt = 1'b0;
        else          w_ctrl_nxt.en = 1'b0;
      end
      default: w_state_nxt = IDLE;
    endcase

    if (w_wr_ctrl) begin
      w_ctrl_nxt = ctrl_t'(din[CTRL_W-1:0]);
      w_flag_nxt = 1'b0;
    end
    if (w_wr_preset) w_preset_nxt = din;
  end

  // Read mux is combinational on addr.
  always_comb begin
    dout = '0;
    case (addr)
      ADDR_CTRL:   dout = {(DATA_W-CTRL_W)'(0), r_ctrl};
      ADDR_PRESET: dout = r_preset;
      ADDR_COUNT:  dout = r_count;
      default:     dout = '0;
    endcase
  end

  assign irq = r_ctrl.im & r_flag;

endmodule

// File: tb/tb_timer_counter.sv
// Directed bench for timer_counter: register access, one-shot, auto-reload,
// masking, boundary cases and mid-count reset.
module tb_timer_counter;
  import timer_pkg::*;

  logic        clk;
  logic        rst;
  logic [1:0]  addr;
  logic        we;
  logic [31:0] din;
  logic [31:0] dout;
  logic        irq;

  int checks = 0;
  int errors = 0;

  timer_counter dut (
    .clk  (clk),
    .rst  (rst),
    .addr (addr),
    .we   (we),
    .din  (din),
    .dout (dout),
    .irq  (irq)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic ticks(input int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  task automatic wr(input logic [1:0] a, input logic [31:0] d);
    addr = a;
    din  = d;
    we   = 1'b1;
    tick();
    we   = 1'b0;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic chk_rd(input string tag, input logic [1:0] a, input logic [31:0] exp);
    addr = a;
    #1;
    chk(tag, dout, exp);
  endtask

  task automatic chk_irq(input string tag, input logic exp);
    chk(tag, 32'(irq), 32'(exp));
  endtask

  initial begin
    rst  = 1'b0;
    addr = 2'd0;
    we   = 1'b0;
    din  = '0;

    // Reset
    ticks(2);
    rst = 1'b1;
    chk_rd("rst_ctrl", 2'd0, 32'd0);
    chk_rd("rst_preset", 2'd1, 32'd0);
    chk_rd("rst_count", 2'd2, 32'd0);
    chk_rd("rst_rsvd", 2'd3, 32'd0);
    chk_irq("rst_irq", 1'b0);
    chk("rst_state", 32'(dut.r_state), 32'(IDLE));

    // One-shot, unmasked, P=15
    wr(2'd1, 32'd15);
    wr(2'd0, 32'h9);
    ticks(2);
    chk_rd("os_count_e2", 2'd2, 32'd15);
    ticks(14);
    chk_rd("os_count_e16", 2'd2, 32'd1);
    chk_irq("os_irq_e16", 1'b0);
    tick();
    chk_rd("os_count_e17", 2'd2, 32'd0);
    chk_irq("os_irq_e17", 1'b1);
    tick();
    chk_irq("os_irq_e18", 1'b1);
    chk_rd("os_ctrl_e18", 2'd0, 32'h8);
    ticks(3);
    chk_irq("os_irq_held", 1'b1);
    chk_rd("os_count_held", 2'd2, 32'd0);
    wr(2'd0, 32'h0);
    chk_irq("os_irq_clr", 1'b0);

    // Auto-reload, P=5: irq at E7 and E15
    wr(2'd1, 32'd5);
    wr(2'd0, 32'hB);
    ticks(6);
    chk_rd("ar_count_e6", 2'd2, 32'd1);
    chk_irq("ar_irq_e6", 1'b0);
    tick();
    chk_irq("ar_irq_e7", 1'b1);
    tick();
    chk_irq("ar_irq_e8", 1'b0);
    chk_rd("ar_ctrl_e8", 2'd0, 32'hB);
    ticks(2);
    chk_rd("ar_reload_e10", 2'd2, 32'd5);
    ticks(4);
    chk_irq("ar_irq_e14", 1'b0);
    tick();
    chk_irq("ar_irq_e15", 1'b1);
    tick();
    chk_irq("ar_irq_e16", 1'b0);
    wr(2'd0, 32'h0);
    ticks(3);

    // Masked interrupt, P=3
    wr(2'd1, 32'd3);
    wr(2'd0, 32'h1);
    ticks(5);
    chk_rd("mk_count_e5", 2'd2, 32'd0);
    chk_irq("mk_irq_e5", 1'b0);
    tick();
    chk_rd("mk_ctrl_en_clr", 2'd0, 32'h0);
    wr(2'd0, 32'h8);
    chk_irq("mk_irq_after_im", 1'b0);
    chk_rd("mk_ctrl_rd", 2'd0, 32'h8);
    wr(2'd0, 32'h0);

    // PRESET = 0: irq at edge 3
    wr(2'd1, 32'd0);
    wr(2'd0, 32'h9);
    ticks(2);
    chk_rd("p0_count_e2", 2'd2, 32'd0);
    chk_irq("p0_irq_e2", 1'b0);
    tick();
    chk_irq("p0_irq_e3", 1'b1);
    wr(2'd0, 32'h0);

    // PRESET write / addr 2 write mid-count, then disable freeze and restart
    wr(2'd1, 32'd20);
    wr(2'd0, 32'h1);
    ticks(4);
    chk_rd("mid_count_e4", 2'd2, 32'd18);
    wr(2'd1, 32'd100);
    chk_rd("mid_preset_wr", 2'd2, 32'd17);
    wr(2'd2, 32'd55);
    chk_rd("mid_count_wr", 2'd2, 32'd16);
    wr(2'd0, 32'h0);
    ticks(3);
    chk_rd("mid_freeze", 2'd2, 32'd15);
    chk_rd("mid_preset_rd", 2'd1, 32'd100);
    chk("mid_state_idle", 32'(dut.r_state), 32'(IDLE));
    wr(2'd0, 32'h1);
    ticks(2);
    chk_rd("mid_restart", 2'd2, 32'd100);
    wr(2'd0, 32'h0);
    ticks(3);

    // CTRL write in INT wins over the FSM clearing Enable/int_flag
    wr(2'd1, 32'd2);
    wr(2'd0, 32'h9);
    ticks(4);
    chk_irq("cf_irq_e4", 1'b1);
    wr(2'd0, 32'h9);
    chk_irq("cf_irq_cleared", 1'b0);
    chk_rd("cf_ctrl_kept", 2'd0, 32'h9);
    ticks(2);
    chk_rd("cf_reloaded", 2'd2, 32'd2);
    wr(2'd0, 32'h0);
    ticks(3);

    // Reset mid-count at COUNT = 7
    wr(2'd1, 32'd10);
    wr(2'd0, 32'h9);
    ticks(5);
    chk_rd("mr_count_7", 2'd2, 32'd7);
    rst = 1'b0;
    tick();
    rst = 1'b1;
    chk_rd("mr_ctrl", 2'd0, 32'd0);
    chk_rd("mr_preset", 2'd1, 32'd0);
    chk_rd("mr_count", 2'd2, 32'd0);
    chk_irq("mr_irq", 1'b0);
    chk("mr_state", 32'(dut.r_state), 32'(IDLE));
    ticks(3);
    chk_rd("mr_count_stays", 2'd2, 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
